// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states, the
// register-zero constant and a struct that groups every pipeline register's
// enable/clear strobes so the control logic can handle them as one value.
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Enable/clear pair of one pipeline register.
    typedef struct packed {
        logic ce;
        logic flush;
    } stage_ctrl_t;

    // Complete set of strobes returned to the datapath.
    typedef struct packed {
        logic        pc_ce;
        logic        pc_src;
        stage_ctrl_t ifid;
        stage_ctrl_t idex;
        stage_ctrl_t exmem;
        stage_ctrl_t memwb;
    } pipe_ctrl_t;

    // Free-running pipeline: everything advances, nothing is cleared.
    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_ce:  1'b1,
        pc_src: 1'b0,
        ifid:   '{ce: 1'b1, flush: 1'b0},
        idex:   '{ce: 1'b1, flush: 1'b0},
        exmem:  '{ce: 1'b1, flush: 1'b0},
        memwb:  '{ce: 1'b1, flush: 1'b0}
    };

    // Held in reset: nothing advances, every stage is cleared.
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_ce:  1'b0,
        pc_src: 1'b0,
        ifid:   '{ce: 1'b0, flush: 1'b1},
        idex:   '{ce: 1'b0, flush: 1'b1},
        exmem:  '{ce: 1'b0, flush: 1'b1},
        memwb:  '{ce: 1'b0, flush: 1'b1}
    };

    // Memory freeze: hold PC through EX/MEM and push a bubble into WB.
    function automatic pipe_ctrl_t freeze_ctrl(input pipe_ctrl_t c);
        pipe_ctrl_t r;
        r             = c;
        r.pc_ce       = 1'b0;
        r.ifid.ce     = 1'b0;
        r.idex.ce     = 1'b0;
        r.exmem.ce    = 1'b0;
        r.memwb.flush = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an instruction in IF/ID that reads the register
// a load in ID/EX is about to write. Register zero never creates a hazard.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rt,
    output logic       o_luse
);

    assign o_luse = i_idex_memread
                 && (i_idex_rt != REG_ZERO)
                 && ((i_idex_rt == i_id_rs) || (i_idex_rt == i_id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline. Produces the clock-enable
// and flush strobes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from load-use,
// taken-branch (resolved in MEM) and multi-cycle data-memory conditions.
// Optional statistics counters are compiled in with `define PIPE_STATS_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ack,
    output logic             pc_ce,
    output logic             pc_src,
    output logic             ifid_ce,
    output logic             ifid_flush,
    output logic             idex_ce,
    output logic             idex_flush,
    output logic             exmem_ce,
    output logic             exmem_flush,
    output logic             memwb_ce,
    output logic             memwb_flush,
    output logic             dmem_req,
`ifdef PIPE_STATS_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             mem_err
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_mem_err;
    logic              w_mem_err_nxt;
    logic              w_mem_op;
    logic              w_freeze;
    logic              w_taken;
    logic              w_luse;
    pipe_ctrl_t        w_ctrl;

    assign w_mem_op = exmem_memread | exmem_memwrite;

    hazard_detect u_hazard_detect (
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_idex_memread (idex_memread),
        .i_idex_rt      (idex_rt),
        .o_luse         (w_luse)
    );

    // Next state, wait counter, timeout flag and whether this cycle freezes.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        w_freeze       = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_op && !dmem_ack) begin
                    w_freeze       = 1'b1;
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    // Release cycle: RUN strobes apply, then back to RUN.
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_MAX) begin
                    // Abandon the access and release exactly as on an ack.
                    w_mem_err_nxt  = 1'b1;
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_freeze       = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Strobe priority: reset, memory freeze, taken branch, load-use bubble.
    always_comb begin
        w_taken = 1'b0;
        w_ctrl  = CTRL_RUN;
        if (w_freeze) begin
            w_ctrl = freeze_ctrl(CTRL_RUN);
        end else if (exmem_branch && exmem_zero) begin
            w_taken           = 1'b1;
            w_ctrl.pc_src     = 1'b1;
            w_ctrl.ifid.flush = 1'b1;
            w_ctrl.idex.flush = 1'b1;
            w_ctrl.exmem.flush = 1'b1;
        end else if (w_luse) begin
            w_ctrl.pc_ce      = 1'b0;
            w_ctrl.ifid.ce    = 1'b0;
            w_ctrl.idex.flush = 1'b1;
        end
        if (rst) begin
            w_taken = 1'b0;
            w_ctrl  = CTRL_RESET;
        end
    end

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    assign pc_ce       = w_ctrl.pc_ce;
    assign pc_src      = w_ctrl.pc_src;
    assign ifid_ce     = w_ctrl.ifid.ce;
    assign ifid_flush  = w_ctrl.ifid.flush;
    assign idex_ce     = w_ctrl.idex.ce;
    assign idex_flush  = w_ctrl.idex.flush;
    assign exmem_ce    = w_ctrl.exmem.ce;
    assign exmem_flush = w_ctrl.exmem.flush;
    assign memwb_ce    = w_ctrl.memwb.ce;
    assign memwb_flush = w_ctrl.memwb.flush;
    assign dmem_req    = w_mem_op && !rst;
    assign mem_err     = r_mem_err;

`ifdef PIPE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counts of PC-stalled cycles and taken-branch flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctrl.pc_ce && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_taken && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    // CNT_W only sizes the statistics counters; keep it referenced here.
    logic [CNT_W-1:0] w_unused_cnt_w;
    assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by randomized traffic, compared every cycle against a rule-level model.
// Builds with or without `define PIPE_STATS_EN.
module tb_pipe_hazard_ctrl;

    localparam int TMO   = 4;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       idex_memread, exmem_branch, exmem_zero;
    logic       exmem_memread, exmem_memwrite, dmem_ack;
    logic       pc_ce, pc_src, ifid_ce, ifid_flush, idex_ce, idex_flush;
    logic       exmem_ce, exmem_flush, memwb_ce, memwb_flush, dmem_req, mem_err;
`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int               m_stall_cnt, m_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: consecutive frozen cycles of the current access, sticky error.
    int         m_frozen;
    bit         m_err;
    bit         m_stall, m_tmo, m_taken, m_luse;
    logic [11:0] m_exp;

    localparam logic [11:0] EXP_RESET = 12'b0001_0101_0100;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .idex_memread   (idex_memread),
        .idex_rt        (idex_rt),
        .exmem_branch   (exmem_branch),
        .exmem_zero     (exmem_zero),
        .exmem_memread  (exmem_memread),
        .exmem_memwrite (exmem_memwrite),
        .dmem_ack       (dmem_ack),
        .pc_ce          (pc_ce),
        .pc_src         (pc_src),
        .ifid_ce        (ifid_ce),
        .ifid_flush     (ifid_flush),
        .idex_ce        (idex_ce),
        .idex_flush     (idex_flush),
        .exmem_ce       (exmem_ce),
        .exmem_flush    (exmem_flush),
        .memwb_ce       (memwb_ce),
        .memwb_flush    (memwb_flush),
        .dmem_req       (dmem_req),
`ifdef PIPE_STATS_EN
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .mem_err        (mem_err)
    );

    function automatic logic [11:0] got_vec();
        return {pc_ce, pc_src, ifid_ce, ifid_flush, idex_ce, idex_flush,
                exmem_ce, exmem_flush, memwb_ce, memwb_flush, dmem_req, mem_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit ld, input int lrt,
                          input bit br, input bit z, input bit mr, input bit mw, input bit ack);
        id_rs          = 5'(rs);
        id_rt          = 5'(rt);
        idex_memread   = ld;
        idex_rt        = 5'(lrt);
        exmem_branch   = br;
        exmem_zero     = z;
        exmem_memread  = mr;
        exmem_memwrite = mw;
        dmem_ack       = ack;
    endtask

    task automatic model_reset();
        m_frozen = 0;
        m_err    = 1'b0;
`ifdef PIPE_STATS_EN
        m_stall_cnt = 0;
        m_flush_cnt = 0;
`endif
    endtask

    // Expected strobes from the hazard rules for the current inputs.
    task automatic model_eval();
        bit mem_op;
        bit lu_raw;
        mem_op = exmem_memread || exmem_memwrite;
        if (m_frozen == 0) begin
            m_tmo   = 1'b0;
            m_stall = mem_op && !dmem_ack;
        end else begin
            m_tmo   = !dmem_ack && (m_frozen >= TMO);
            m_stall = !dmem_ack && !m_tmo;
        end
        lu_raw  = idex_memread && (idex_rt != 0) && (idex_rt == id_rs || idex_rt == id_rt);
        m_taken = !m_stall && exmem_branch && exmem_zero;
        m_luse  = !m_stall && !m_taken && lu_raw;
        m_exp = {!(m_stall || m_luse), m_taken,
                 !(m_stall || m_luse), m_taken,
                 !m_stall, m_taken || m_luse,
                 !m_stall, m_taken,
                 1'b1, m_stall,
                 mem_op, m_err};
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input string tag);
        @(negedge clk);
        model_eval();
        check(tag, 32'(got_vec()), 32'(m_exp));
`ifdef PIPE_STATS_EN
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
        check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
`endif
        @(posedge clk);
        m_frozen = m_stall ? m_frozen + 1 : 0;
        if (m_tmo) m_err = 1'b1;
`ifdef PIPE_STATS_EN
        if (!m_exp[11] && m_stall_cnt < (2 ** CNT_W) - 1) m_stall_cnt++;
        if (m_taken && m_flush_cnt < (2 ** CNT_W) - 1) m_flush_cnt++;
`endif
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1 check(tag, 32'(got_vec()), 32'(EXP_RESET));
`ifdef PIPE_STATS_EN
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'd0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ack_bias;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset_state", 32'(got_vec()), 32'(EXP_RESET));
        rst = 1'b0;

        step("idle");

        // Load-use: one bubble, then the bubble removes the load from ID/EX.
        set_in(5, 0, 1, 5, 0, 0, 0, 0, 0); step("luse_rs");
        set_in(5, 0, 0, 5, 0, 0, 0, 0, 0); step("luse_after");
        set_in(1, 7, 1, 7, 0, 0, 0, 0, 0); step("luse_rt");
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0); step("zero_reg");
        set_in(3, 4, 1, 6, 0, 0, 0, 0, 0); step("luse_nomatch");

        // Taken and not-taken branch.
        set_in(0, 0, 0, 0, 1, 1, 0, 0, 0); step("br_taken");
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); step("br_not_taken");

        // Three-cycle memory wait, release on ack, back to RUN.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) step("mem_wait");
        dmem_ack = 1'b1; step("mem_release");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mem_run");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); step("mem_ack_now");

        // Simultaneous events.
        set_in(5, 0, 1, 5, 1, 1, 0, 0, 0); step("br_over_luse");
        set_in(0, 0, 0, 0, 1, 1, 1, 0, 0);
        repeat (2) step("stall_over_br");
        dmem_ack = 1'b1; step("release_br");

        // Timeout: TMO frozen cycles, then a release and a sticky error.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (TMO + 1) step("timeout");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step("err_sticky");
        check("mem_err_sticky", 32'(mem_err), 32'd1);

        // Reset during a wait aborts it and clears the error.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) step("pre_rst_wait");
        do_reset("rst_mid_wait");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("post_rst");

        // Randomized traffic with phases of slow or dead memory.
        ack_bias = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) ack_bias = $urandom_range(0, 7);
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 7) < ack_bias);
            step("rand");
            if ($urandom_range(0, 299) == 0) do_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
